instruction_decode: RTL and testbench
=====================================

Name: instruction_decode

Overview:
- Decode/operand-read stage of the 20-bit pipeline processor.
- Sits between fetch and the execute stage, and produces the execute stage's inputs: ALU control, opA, opB and the propagated instruction.
- Holds the register file, accepts writebacks, and stalls fetch on RAW hazards using a per-register pending-write scoreboard.
- Output is registered: one ID/EX pipeline register.

Parameters:
- DATA_W, 20: register/operand width.
- REG_AW, 4: register address width (16 registers).
- SB_W, 2: width of each scoreboard counter (max in-flight writes per register = 2^SB_W-1).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- if_valid  in  1  fetch presents a valid instruction.
- instruction  in  20  fetched instruction.
- if_ready  out  1  decode accepts instruction this cycle (0 = stall fetch).
- wb_we  in  1  writeback enable.
- wb_rd  in  REG_AW  writeback destination register.
- wb_data  in  DATA_W  writeback data.
- ex_valid  out  1  ID/EX register holds a valid instruction.
- control  out  2  ALU op (00 add, 01 or, 10 and, 11 not).
- opA  out  DATA_W  rs1 operand.
- opB  out  DATA_W  rs2 operand.
- ex_rd  out  REG_AW  destination register.
- ex_we  out  1  instruction writes ex_rd.
- instructionPropagation  out  20  instruction copy for later stages.
- illegal  out  1  pulse: an undefined opcode was issued as a NOP.

Behaviour:
- Encoding: opcode [19:16], rd [15:12], rs1 [11:8], rs2 [7:4]; [3:0] ignored.
- Opcode mapping:
  - 0000 = NOP (we=0).
  - 0001 = ADD, 0010 = OR, 0011 = AND: control 00 / 01 / 10 respectively, we=1.
  - 0100 = NOT: control 11, we=1, rs2 ignored and never causes a stall.
  - 0101-1111 = illegal: issued as a NOP (we=0, control 00), illegal=1 for that issue cycle.
- r0 always reads 0. Writes to r0 are dropped. r0 is never pending and never tracked by the scoreboard.
- Register file: written on the clock edge when wb_we=1.
  - Reads are combinational with write-through: if wb_we and wb_rd==rs (rs≠0), the read returns wb_data in the same cycle.
- Scoreboard: one SB_W-bit counter per register.
  - eff[r] = cnt[r] - (wb_we && wb_rd==r).
  - A source rs is hazarded when rs≠0, rs is used by the opcode, and eff[rs]≠0.
  - A full stall occurs when rd≠0, we=1 and eff[rd]==2^SB_W-1.
- if_ready = 0 on any hazard or full stall, else 1. It is combinational from instruction, the scoreboard and the wb inputs.
- Issue condition: if_valid && if_ready.
- On issue (rising edge):
  - The ID/EX register loads: ex_valid=1, control, opA, opB (post-bypass), ex_rd, ex_we, instructionPropagation=instruction, illegal.
  - cnt[rd] increments if ex_we and rd≠0.
- On a non-issue cycle, the ID/EX register loads a bubble: ex_valid=0, ex_we=0, illegal=0, control=00, opA=opB=0, ex_rd=0, instructionPropagation=0.
- A writeback with wb_we and wb_rd≠0 decrements cnt[wb_rd].
  - If the same cycle also issues to the same rd, the counter is unchanged.
  - A decrement when the counter is already 0 is a protocol error: the counter stays at 0 (no underflow).
- Latency: decode to ex_* outputs is 1 cycle. A stalled instruction issues in the cycle its last blocking writeback arrives.
- Reset (asynchronous, reset=0):
  - All ex_* outputs, opA, opB, control, instructionPropagation and illegal are 0.
  - All scoreboard counters are 0.
  - All registers are 0.
  - if_ready reflects the idle scoreboard, i.e. 1.
  - Reset mid-stall discards the stalled instruction; fetch must re-present it.

Decomposition:
- Package decode_pkg:
  - Opcode constants OP_NOP, OP_ADD, OP_OR, OP_AND, OP_NOT.
  - ALU control constants ALU_ADD/OR/AND/NOT.
  - Field bit positions.
  - Width constants.
- One sub-module register_file: 2 read ports, 1 write port, write-through bypass, r0 hardwired to 0.
- Scoreboard and ID/EX register stay in instruction_decode.

Test Plan:
- Reset, then wb r1=5 and r2=3, then issue ADD r3,r1,r2 → next cycle ex_valid=1, control=00, opA=5, opB=3, ex_rd=3, ex_we=1.
- ADD r3,r1,r2 then OR r4,r3,r1 back-to-back → if_ready=0 for the OR and ex_valid=0 bubbles; on the cycle wb r3=8 arrives, the OR issues with opA=8 (bypass) and opB=5.
- Three ADDs to r5 with no writeback → the third issues (cnt=3); a fourth ADD to r5 stalls until one wb r5 occurs, then issues.
- Opcode 0111 → ex_valid=1, ex_we=0, illegal=1 for one cycle; NOT r6,r1,r7 with r7 pending → no stall, control=11.
- Reads of r0 → 0 after "wb r0=9"; async reset asserted mid-stall → outputs 0 immediately and if_ready=1 after release.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared constants and the ID/EX bundle for the
// 20-bit decode/operand-read stage.
package decode_pkg;

    localparam int DATA_W = 20;
    localparam int REG_AW = 4;
    localparam int SB_W   = 2;
    localparam int INSN_W = 20;
    localparam int NREG   = 1 << REG_AW;

    localparam logic [SB_W-1:0] SB_MAX = {SB_W{1'b1}};

    localparam int OPC_LO = 16;
    localparam int RD_LO  = 12;
    localparam int RS1_LO = 8;
    localparam int RS2_LO = 4;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    typedef struct packed {
        logic              valid;
        logic [1:0]        control;
        logic [DATA_W-1:0] opa;
        logic [DATA_W-1:0] opb;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic [INSN_W-1:0] insn;
        logic              illegal;
    } id_ex_t;

endpackage

// File: rtl/instruction_decode_if.sv
// Fetch-to-decode valid/ready handshake.
interface instruction_decode_if
    import decode_pkg::*;
();
    logic              if_valid;
    logic [INSN_W-1:0] instruction;
    logic              if_ready;

    modport master (
        output if_valid,
        output instruction,
        input  if_ready
    );

    modport slave (
        input  if_valid,
        input  instruction,
        output if_ready
    );
endinterface

// File: rtl/instruction_decode_register_file.sv
// 2R1W register file, r0 hardwired to zero,
// same-cycle writeback forwarded to the read ports.
module register_file
    import decode_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                mem[r] <= '0;
            end
        end else if (we && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = mem[ra1];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (we && wa == ra1) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = mem[ra2];
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (we && wa == ra2) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: field decode, scoreboard RAW/full
// stalls, register read and the ID/EX register.
module instruction_decode
    import decode_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    instruction_decode_if.slave  fe,
    input  logic                 wb_we,
    input  logic [REG_AW-1:0]    wb_rd,
    input  logic [DATA_W-1:0]    wb_data,
    output logic                 ex_valid,
    output logic [1:0]           control,
    output logic [DATA_W-1:0]    opA,
    output logic [DATA_W-1:0]    opB,
    output logic [REG_AW-1:0]    ex_rd,
    output logic                 ex_we,
    output logic [INSN_W-1:0]    instructionPropagation,
    output logic                 illegal
);

    logic [3:0]        opc;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;

    assign opc = fe.instruction[OPC_LO +: 4];
    assign rd  = fe.instruction[RD_LO  +: REG_AW];
    assign rs1 = fe.instruction[RS1_LO +: REG_AW];
    assign rs2 = fe.instruction[RS2_LO +: REG_AW];

    logic       dec_we;
    logic [1:0] dec_ctl;
    logic       use1;
    logic       use2;
    logic       dec_ill;

    always_comb begin
        dec_we  = 1'b0;
        dec_ctl = ALU_ADD;
        use1    = 1'b0;
        use2    = 1'b0;
        dec_ill = 1'b0;
        unique case (1'b1)
            (opc == OP_NOP): begin
            end
            (opc == OP_ADD): begin
                dec_we = 1'b1;
                use1   = 1'b1;
                use2   = 1'b1;
            end
            (opc == OP_OR): begin
                dec_we  = 1'b1;
                dec_ctl = ALU_OR;
                use1    = 1'b1;
                use2    = 1'b1;
            end
            (opc == OP_AND): begin
                dec_we  = 1'b1;
                dec_ctl = ALU_AND;
                use1    = 1'b1;
                use2    = 1'b1;
            end
            (opc == OP_NOT): begin
                dec_we  = 1'b1;
                dec_ctl = ALU_NOT;
                use1    = 1'b1;
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
    end

    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;

    register_file u_rf (
        .clock (clock),
        .reset (reset),
        .ra1   (rs1),
        .ra2   (rs2),
        .rd1   (rdata1),
        .rd2   (rdata2),
        .we    (wb_we),
        .wa    (wb_rd),
        .wd    (wb_data)
    );

    logic [SB_W-1:0] cnt     [NREG];
    logic [SB_W-1:0] eff     [NREG];
    logic [SB_W-1:0] cnt_nxt [NREG];
    logic            dec_hit [NREG];

    // A counter already at 0 never wraps under a stray writeback.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            dec_hit[r] = wb_we && (wb_rd == REG_AW'(r)) && (r != 0);
            eff[r]     = cnt[r];
            if (dec_hit[r] && cnt[r] != '0) begin
                eff[r] = cnt[r] - 1'b1;
            end
        end
    end

    logic haz1;
    logic haz2;
    logic full;
    logic issue;

    assign haz1  = use1 && rs1 != '0 && eff[rs1] != '0;
    assign haz2  = use2 && rs2 != '0 && eff[rs2] != '0;
    assign full  = dec_we && rd != '0 && eff[rd] == SB_MAX;
    assign fe.if_ready = !(haz1 || haz2 || full);
    assign issue = fe.if_valid && fe.if_ready;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt[r] = cnt[r];
            if (issue && dec_we && rd != '0 && rd == REG_AW'(r)) begin
                if (!dec_hit[r]) begin
                    cnt_nxt[r] = cnt[r] + 1'b1;
                end
            end else begin
                cnt_nxt[r] = eff[r];
            end
        end
    end

    id_ex_t nxt;
    id_ex_t idex;

    always_comb begin
        nxt         = '0;
        nxt.valid   = 1'b1;
        nxt.control = dec_ctl;
        nxt.opa     = rdata1;
        nxt.opb     = rdata2;
        nxt.rd      = rd;
        nxt.we      = dec_we;
        nxt.insn    = fe.instruction;
        nxt.illegal = dec_ill;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idex <= '0;
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            idex <= issue ? nxt : '0;
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
        end
    end

    assign ex_valid               = idex.valid;
    assign control                = idex.control;
    assign opA                    = idex.opa;
    assign opB                    = idex.opb;
    assign ex_rd                  = idex.rd;
    assign ex_we                  = idex.we;
    assign instructionPropagation = idex.insn;
    assign illegal                = idex.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode.
module tb_instruction_decode;
    import decode_pkg::*;

    logic              clock;
    logic              reset;
    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              ex_valid;
    logic [1:0]        control;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_we;
    logic [INSN_W-1:0] instructionPropagation;
    logic              illegal;

    int total = 0;
    int bad   = 0;

    instruction_decode_if fe ();

    instruction_decode dut (
        .clock                  (clock),
        .reset                  (reset),
        .fe                     (fe.slave),
        .wb_we                  (wb_we),
        .wb_rd                  (wb_rd),
        .wb_data                (wb_data),
        .ex_valid               (ex_valid),
        .control                (control),
        .opA                    (opA),
        .opB                    (opB),
        .ex_rd                  (ex_rd),
        .ex_we                  (ex_we),
        .instructionPropagation (instructionPropagation),
        .illegal                (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [19:0] insn,
                         input logic we, input logic [3:0] rd,
                         input logic [19:0] d);
        fe.if_valid    = v;
        fe.instruction = insn;
        wb_we          = we;
        wb_rd          = rd;
        wb_data        = d;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 20'h0, 1'b0, 4'h0, 20'h0);
        #3;
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_opA", 32'(opA), 32'd0);
        chk("rst_ready", 32'(fe.if_ready), 32'd1);
        tick();
        reset = 1'b1;
        tick();

        drive(1'b0, 20'h0, 1'b1, 4'd1, 20'd5);
        tick();
        drive(1'b0, 20'h0, 1'b1, 4'd2, 20'd3);
        tick();

        drive(1'b1, 20'h13120, 1'b0, 4'd0, 20'd0);
        chk("add_ready", 32'(fe.if_ready), 32'd1);
        tick();
        chk("add_valid", 32'(ex_valid), 32'd1);
        chk("add_ctl", 32'(control), 32'd0);
        chk("add_opA", 32'(opA), 32'd5);
        chk("add_opB", 32'(opB), 32'd3);
        chk("add_rd", 32'(ex_rd), 32'd3);
        chk("add_we", 32'(ex_we), 32'd1);
        chk("add_insn", 32'(instructionPropagation), 32'h13120);

        drive(1'b1, 20'h24310, 1'b0, 4'd0, 20'd0);
        chk("or_stall", 32'(fe.if_ready), 32'd0);
        tick();
        chk("or_bubble", 32'(ex_valid), 32'd0);
        chk("or_bubble_op", 32'(opA), 32'd0);
        chk("or_bubble_insn", 32'(instructionPropagation), 32'd0);

        drive(1'b1, 20'h24310, 1'b1, 4'd3, 20'd8);
        chk("or_ready_wb", 32'(fe.if_ready), 32'd1);
        tick();
        chk("or_valid", 32'(ex_valid), 32'd1);
        chk("or_ctl", 32'(control), 32'd1);
        chk("or_opA_byp", 32'(opA), 32'd8);
        chk("or_opB", 32'(opB), 32'd5);
        chk("or_rd", 32'(ex_rd), 32'd4);

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 20'h15120, 1'b0, 4'd0, 20'd0);
            chk("r5_ready", 32'(fe.if_ready), 32'd1);
            tick();
            chk("r5_valid", 32'(ex_valid), 32'd1);
        end
        drive(1'b1, 20'h15120, 1'b0, 4'd0, 20'd0);
        chk("r5_full", 32'(fe.if_ready), 32'd0);
        tick();
        chk("r5_full_bub", 32'(ex_valid), 32'd0);
        drive(1'b1, 20'h15120, 1'b1, 4'd5, 20'd7);
        chk("r5_ready_wb", 32'(fe.if_ready), 32'd1);
        tick();
        chk("r5_4th_valid", 32'(ex_valid), 32'd1);
        chk("r5_4th_rd", 32'(ex_rd), 32'd5);
        drive(1'b1, 20'h15120, 1'b0, 4'd0, 20'd0);
        chk("r5_still_full", 32'(fe.if_ready), 32'd0);

        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 20'h0, 1'b1, 4'd5, 20'd7);
            tick();
        end
        drive(1'b1, 20'h16500, 1'b0, 4'd0, 20'd0);
        chk("r5_no_underflow", 32'(fe.if_ready), 32'd1);
        tick();
        chk("r5_read_opA", 32'(opA), 32'd7);

        drive(1'b1, 20'h71120, 1'b0, 4'd0, 20'd0);
        chk("ill_ready", 32'(fe.if_ready), 32'd1);
        tick();
        chk("ill_valid", 32'(ex_valid), 32'd1);
        chk("ill_we", 32'(ex_we), 32'd0);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_ctl", 32'(control), 32'd0);
        drive(1'b0, 20'h0, 1'b0, 4'd0, 20'd0);
        tick();
        chk("ill_pulse", 32'(illegal), 32'd0);

        drive(1'b1, 20'h17110, 1'b0, 4'd0, 20'd0);
        tick();
        drive(1'b1, 20'h46170, 1'b0, 4'd0, 20'd0);
        chk("not_ready", 32'(fe.if_ready), 32'd1);
        tick();
        chk("not_ctl", 32'(control), 32'd3);
        chk("not_rd", 32'(ex_rd), 32'd6);
        chk("not_opA", 32'(opA), 32'd5);
        drive(1'b0, 20'h46710, 1'b0, 4'd0, 20'd0);
        chk("not_rs1_haz", 32'(fe.if_ready), 32'd0);

        drive(1'b0, 20'h0, 1'b1, 4'd0, 20'd9);
        tick();
        drive(1'b1, 20'h18000, 1'b1, 4'd0, 20'd9);
        chk("r0_ready", 32'(fe.if_ready), 32'd1);
        tick();
        chk("r0_opA", 32'(opA), 32'd0);
        chk("r0_opB", 32'(opB), 32'd0);
        chk("r0_valid", 32'(ex_valid), 32'd1);

        drive(1'b1, 20'h19700, 1'b0, 4'd0, 20'd0);
        chk("pre_rst_stall", 32'(fe.if_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ex_valid), 32'd0);
        chk("mid_rst_rd", 32'(ex_rd), 32'd0);
        chk("mid_rst_we", 32'(ex_we), 32'd0);
        chk("mid_rst_insn", 32'(instructionPropagation), 32'd0);
        tick();
        reset = 1'b1;
        drive(1'b0, 20'h19700, 1'b0, 4'd0, 20'd0);
        chk("post_rst_ready", 32'(fe.if_ready), 32'd1);
        tick();
        chk("post_rst_bubble", 32'(ex_valid), 32'd0);
        drive(1'b1, 20'h1a120, 1'b0, 4'd0, 20'd0);
        tick();
        chk("post_rst_opA", 32'(opA), 32'd0);
        chk("post_rst_opB", 32'(opB), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
